// File: rtl/exec_stage_unit_pkg.sv
// Shared constants for the multi-cycle execution stage: stage encodings, ALU opcodes, widths.
package exec_stage_unit_pkg;

    localparam int WIDTH      = 32;
    localparam int STAGE_W    = 3;
    localparam int OP_W       = 3;
    localparam int NUM_STAGES = 5;

    localparam logic [STAGE_W-1:0] STAGE_INSTR_FETCH = 3'd0;
    localparam logic [STAGE_W-1:0] STAGE_DECODE      = 3'd1;
    localparam logic [STAGE_W-1:0] STAGE_EXECUTE     = 3'd2;
    localparam logic [STAGE_W-1:0] STAGE_MEM_WB      = 3'd3;
    localparam logic [STAGE_W-1:0] STAGE_PC_UPDATE   = 3'd4;

    localparam logic [OP_W-1:0] OP_ADD = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB = 3'd1;
    localparam logic [OP_W-1:0] OP_AND = 3'd2;
    localparam logic [OP_W-1:0] OP_OR  = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR = 3'd4;
    localparam logic [OP_W-1:0] OP_SHL = 3'd5;
    localparam logic [OP_W-1:0] OP_SHR = 3'd6;
    localparam logic [OP_W-1:0] OP_SLT = 3'd7;

endpackage

// File: rtl/exec_stage_unit_stage_counter.sv
// Free-running wrapping stage counter with synchronous active-high reset.
// Any out-of-range value returns to 0 on the next edge.
module stage_counter #(
    parameter int N = 5,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    output logic [W-1:0] stage
);

    logic [W-1:0] stage_r;
    logic [W-1:0] stage_next_s;

    // Next-stage decode: wrap at N-1, recover from illegal encodings.
    always_comb begin
        stage_next_s = {W{1'b0}};
        if (stage_r >= W'(N - 1)) begin
            stage_next_s = {W{1'b0}};
        end else begin
            stage_next_s = stage_r + {{(W-1){1'b0}}, 1'b1};
        end
    end

    // Stage register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_r <= {W{1'b0}};
        end else begin
            stage_r <= stage_next_s;
        end
    end

    assign stage = stage_r;

endmodule

// File: rtl/exec_stage_unit.sv
// Multi-cycle CPU sequencing core: stage counter, ALU operand mux and a 32-bit combinational ALU.
module exec_stage_unit
    import exec_stage_unit_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   PC_output,
    input  logic [OP_W-1:0]    alu_operation,
    input  logic [WIDTH-1:0]   reg_value_0,
    input  logic [WIDTH-1:0]   reg_value_1,
    output logic [STAGE_W-1:0] current_stage,
    output logic               is_stage_instr_fetch,
    output logic               is_stage_PC_update,
    output logic [WIDTH-1:0]   alu_in0,
    output logic [WIDTH-1:0]   alu_in1,
    output logic [OP_W-1:0]    alu_op_select,
    output logic [WIDTH-1:0]   alu_result
);

    logic [STAGE_W-1:0] stage_s;
    logic [WIDTH-1:0]   alu_result_s;
    logic [4:0]         shamt_s;

    stage_counter #(
        .N (NUM_STAGES),
        .W (STAGE_W)
    ) u_stage_counter (
        .clk   (clk),
        .rst   (rst),
        .stage (stage_s)
    );

    assign current_stage        = stage_s;
    assign is_stage_instr_fetch = (stage_s == STAGE_INSTR_FETCH);
    assign is_stage_PC_update   = (stage_s == STAGE_PC_UPDATE);

    // Operand mux: PC update reuses the ALU as the PC incrementer (word-addressed memory).
    always_comb begin
        alu_in0       = reg_value_0;
        alu_in1       = reg_value_1;
        alu_op_select = alu_operation;
        if (stage_s == STAGE_PC_UPDATE) begin
            alu_in0       = PC_output;
            alu_in1       = {{(WIDTH-1){1'b0}}, 1'b1};
            alu_op_select = OP_ADD;
        end else begin
            alu_in0       = reg_value_0;
            alu_in1       = reg_value_1;
            alu_op_select = alu_operation;
        end
    end

    assign shamt_s = alu_in1[4:0];

    // ALU: modulo-2^WIDTH arithmetic, logical shifts, signed set-less-than.
    always_comb begin
        alu_result_s = {WIDTH{1'b0}};
        case (alu_op_select)
            OP_ADD:  alu_result_s = alu_in0 + alu_in1;
            OP_SUB:  alu_result_s = alu_in0 - alu_in1;
            OP_AND:  alu_result_s = alu_in0 & alu_in1;
            OP_OR:   alu_result_s = alu_in0 | alu_in1;
            OP_XOR:  alu_result_s = alu_in0 ^ alu_in1;
            OP_SHL:  alu_result_s = alu_in0 << shamt_s;
            OP_SHR:  alu_result_s = alu_in0 >> shamt_s;
            OP_SLT:  alu_result_s = {{(WIDTH-1){1'b0}}, ($signed(alu_in0) < $signed(alu_in1))};
            default: alu_result_s = {WIDTH{1'b0}};
        endcase
    end

    assign alu_result = alu_result_s;

endmodule

// File: tb/tb_exec_stage_unit.sv
// Directed and table-driven self-checking bench for exec_stage_unit.
module tb_exec_stage_unit;

    logic        clk;
    logic        rst;
    logic [31:0] PC_output;
    logic [2:0]  alu_operation;
    logic [31:0] reg_value_0;
    logic [31:0] reg_value_1;
    logic [2:0]  current_stage;
    logic        is_stage_instr_fetch;
    logic        is_stage_PC_update;
    logic [31:0] alu_in0;
    logic [31:0] alu_in1;
    logic [2:0]  alu_op_select;
    logic [31:0] alu_result;

    int n_cmp  = 0;
    int n_fail = 0;

    exec_stage_unit dut (
        .clk                  (clk),
        .rst                  (rst),
        .PC_output            (PC_output),
        .alu_operation        (alu_operation),
        .reg_value_0          (reg_value_0),
        .reg_value_1          (reg_value_1),
        .current_stage        (current_stage),
        .is_stage_instr_fetch (is_stage_instr_fetch),
        .is_stage_PC_update   (is_stage_PC_update),
        .alu_in0              (alu_in0),
        .alu_in1              (alu_in1),
        .alu_op_select        (alu_op_select),
        .alu_result           (alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  stage;
        logic [2:0]  op;
        logic [31:0] r0;
        logic [31:0] r1;
        logic [31:0] pc;
        logic [31:0] e_in0;
        logic [31:0] e_in1;
        logic [2:0]  e_op;
        logic [31:0] e_res;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Step the free-running counter until it reaches stage s (bounded).
    task automatic goto_stage(input logic [2:0] s);
        for (int i = 0; i < 8 && current_stage !== s; i++) tick();
        check("goto_stage", {29'd0, current_stage}, {29'd0, s});
    endtask

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << b[4:0];
            3'd6:    return a >> b[4:0];
            default: return (sa < sb) ? 32'd1 : 32'd0;
        endcase
    endfunction

    function automatic vec_t mk(input string n, input logic [2:0] s, input logic [2:0] op,
                                input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] pc,
                                input logic [31:0] ei0, input logic [31:0] ei1, input logic [2:0] eop,
                                input logic [31:0] eres);
        vec_t v;
        v.name = n; v.stage = s; v.op = op; v.r0 = r0; v.r1 = r1; v.pc = pc;
        v.e_in0 = ei0; v.e_in1 = ei1; v.e_op = eop; v.e_res = eres;
        return v;
    endfunction

    initial begin
        rst = 1'b1;
        PC_output = 32'h0000_0100;
        alu_operation = 3'd0;
        reg_value_0 = 32'h0000_1111;
        reg_value_1 = 32'h0000_2222;

        vecs.push_back(mk("add_wrap", 3'd2, 3'd0, 32'hFFFF_FFFF, 32'h2, 32'h0, 32'hFFFF_FFFF, 32'h2, 3'd0, 32'h0000_0001));
        vecs.push_back(mk("sub",      3'd2, 3'd1, 32'hFFFF_FFFF, 32'h2, 32'h0, 32'hFFFF_FFFF, 32'h2, 3'd1, 32'hFFFF_FFFD));
        vecs.push_back(mk("pc_inc",   3'd4, 3'd4, 32'h1234_5678, 32'h9ABC_DEF0, 32'h7FF, 32'h7FF, 32'h1, 3'd0, 32'h0000_0800));
        vecs.push_back(mk("shl",      3'd1, 3'd5, 32'h8000_0000, 32'h23, 32'h0, 32'h8000_0000, 32'h23, 3'd5, 32'h0000_0000));
        vecs.push_back(mk("shr",      3'd1, 3'd6, 32'h8000_0000, 32'h23, 32'h0, 32'h8000_0000, 32'h23, 3'd6, 32'h1000_0000));
        vecs.push_back(mk("slt_neg",  3'd1, 3'd7, 32'h8000_0000, 32'h23, 32'h0, 32'h8000_0000, 32'h23, 3'd7, 32'h0000_0001));
        vecs.push_back(mk("and",      3'd1, 3'd2, 32'h8000_0000, 32'h23, 32'h0, 32'h8000_0000, 32'h23, 3'd2, 32'h0000_0000));
        vecs.push_back(mk("or",       3'd1, 3'd3, 32'h8000_0000, 32'h23, 32'h0, 32'h8000_0000, 32'h23, 3'd3, 32'h8000_0023));
        vecs.push_back(mk("slt_pos",  3'd3, 3'd7, 32'h23, 32'h8000_0000, 32'h0, 32'h23, 32'h8000_0000, 3'd7, 32'h0000_0000));
        vecs.push_back(mk("xor",      3'd0, 3'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd4, 32'hFF00_FF00));
        vecs.push_back(mk("shl_amt32",3'd3, 3'd5, 32'h1234_5678, 32'h20, 32'h0, 32'h1234_5678, 32'h20, 3'd5, 32'h1234_5678));
        vecs.push_back(mk("shr_31",   3'd2, 3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd6, 32'h0000_0001));

        // Reset state; combinational path stays live while rst is held.
        tick();
        check("rst_stage", {29'd0, current_stage}, 32'd0);
        check("rst_fetch_flag", {31'd0, is_stage_instr_fetch}, 32'd1);
        check("rst_pcu_flag", {31'd0, is_stage_PC_update}, 32'd0);
        check("rst_in0", alu_in0, 32'h0000_1111);
        check("rst_result", alu_result, 32'h0000_3333);
        rst = 1'b0;

        // Twelve-sample stage sequence 0,1,2,3,4,0,1,...
        for (int i = 1; i < 12; i++) begin
            tick();
            check("seq_stage", {29'd0, current_stage}, i % 5);
            check("seq_fetch_flag", {31'd0, is_stage_instr_fetch}, ((i % 5) == 0) ? 32'd1 : 32'd0);
            check("seq_pcu_flag", {31'd0, is_stage_PC_update}, ((i % 5) == 4) ? 32'd1 : 32'd0);
        end

        // Mid-instruction reset at stage 3.
        goto_stage(3'd3);
        rst = 1'b1;
        tick();
        check("midrst_stage", {29'd0, current_stage}, 32'd0);
        rst = 1'b0;
        tick();
        check("resume_stage1", {29'd0, current_stage}, 32'd1);
        tick();
        check("resume_stage2", {29'd0, current_stage}, 32'd2);

        // Directed vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            goto_stage(vecs[i].stage);
            alu_operation = vecs[i].op;
            reg_value_0   = vecs[i].r0;
            reg_value_1   = vecs[i].r1;
            PC_output     = vecs[i].pc;
            #1;
            check({vecs[i].name, "_in0"}, alu_in0, vecs[i].e_in0);
            check({vecs[i].name, "_in1"}, alu_in1, vecs[i].e_in1);
            check({vecs[i].name, "_op"}, {29'd0, alu_op_select}, {29'd0, vecs[i].e_op});
            check({vecs[i].name, "_res"}, alu_result, vecs[i].e_res);
        end

        // Every opcode in every register-operand stage with random operands.
        for (int s = 0; s < 4; s++) begin
            for (int op = 0; op < 8; op++) begin
                logic [31:0] a;
                logic [31:0] b;
                goto_stage(3'(s));
                a = $urandom;
                b = $urandom;
                alu_operation = 3'(op);
                reg_value_0   = a;
                reg_value_1   = b;
                PC_output     = $urandom;
                #1;
                check("rnd_in0", alu_in0, a);
                check("rnd_in1", alu_in1, b);
                check("rnd_op", {29'd0, alu_op_select}, op);
                check("rnd_res", alu_result, ref_alu(3'(op), a, b));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
